// File: rtl/order_sequencer.sv
// order_sequencer: walks a table of multi-word orders, handing each one to a compute
// core and advancing on the core's finish edge until a zero opcode or the last entry.
//
// Ports:
//   system_clk        sole clock, rising edge
//   rst_n             synchronous active-low reset
//   task_start        one-cycle pulse, starts a run at START_LAYER (ignored while busy)
//   abort             level, returns to idle from any state, no task_done
//   calculate_finish  level from the core; a fresh 0->1 in WAIT retires the order
//   calculate_start   one-cycle pulse, order_bus is ready to execute
//   cfg_we/addr/word_sel/wdata  table field write port, honoured only in idle
//   order_bus         current order, field i at [32*i +: 32], opcode in field 0 [2:0]
//   order_valid       order_bus holds a fetched, not yet retired order
//   layer_idx         table index of the order on order_bus
//   busy              run in progress
//   task_done         one-cycle pulse at normal end of run
module order_sequencer #(
  parameter int unsigned ORDER_WORDS = 16,
  parameter int unsigned ORDER_DEPTH = 64,
  parameter int unsigned START_LAYER = 0,
  localparam int unsigned ADDR_W = $clog2(ORDER_DEPTH),
  localparam int unsigned SEL_W = (ORDER_WORDS > 1) ? $clog2(ORDER_WORDS) : 1
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic                      task_start,
  input  logic                      abort,
  input  logic                      calculate_finish,
  output logic                      calculate_start,
  input  logic                      cfg_we,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [SEL_W-1:0]          cfg_word_sel,
  input  logic [31:0]               cfg_wdata,
  output logic [ORDER_WORDS*32-1:0] order_bus,
  output logic                      order_valid,
  output logic [ADDR_W-1:0]         layer_idx,
  output logic                      busy,
  output logic                      task_done
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLatch, StIssue, StWait, StNext, StDone
  } state_e;

  state_e state_q, state_d;

  logic [ORDER_WORDS*32-1:0] mem [ORDER_DEPTH];
  logic [ORDER_WORDS*32-1:0] rd_data_q;
  logic [ADDR_W-1:0]         rd_addr_q;
  logic [ORDER_WORDS*32-1:0] order_bus_q;
  logic [ADDR_W-1:0]         layer_idx_q;
  logic                      finish_q;
  logic                      calc_start_q;
  logic                      order_valid_q;
  logic                      task_done_q;
  logic                      finish_edge;
  logic                      last_entry;
  logic                      zero_opcode;

  assign finish_edge = calculate_finish & ~finish_q;
  assign last_entry  = (rd_addr_q == ADDR_W'(ORDER_DEPTH - 1));
  assign zero_opcode = (rd_data_q[2:0] == 3'd0);

  // Table: one field written per cycle while idle, whole entry read with 1-cycle latency.
  always_ff @(posedge system_clk) begin
    if (cfg_we && (state_q == StIdle)) begin
      mem[cfg_addr][32*cfg_word_sel +: 32] <= cfg_wdata;
    end
    rd_data_q <= mem[rd_addr_q];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (task_start) state_d = StFetch;
      StFetch: state_d = StLatch;
      StLatch: state_d = zero_opcode ? StDone : StIssue;
      StIssue: state_d = StWait;
      StWait:  if (finish_edge) state_d = StNext;
      StNext:  state_d = last_entry ? StDone : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides everything, including a simultaneous start in idle.
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rd_addr_q     <= ADDR_W'(START_LAYER);
      order_bus_q   <= '0;
      layer_idx_q   <= '0;
      finish_q      <= 1'b0;
      calc_start_q  <= 1'b0;
      order_valid_q <= 1'b0;
      task_done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= calculate_finish;
      // Pulses are registered on leaving ISSUE/DONE so an abort there suppresses them.
      calc_start_q <= (state_q == StIssue) && !abort;
      task_done_q  <= (state_q == StDone) && !abort;

      if (abort) begin
        order_valid_q <= 1'b0;
      end else if (state_q == StLatch) begin
        order_valid_q <= !zero_opcode;
      end else if ((state_q == StWait) && finish_edge) begin
        order_valid_q <= 1'b0;
      end

      if ((state_q == StIdle) && task_start && !abort) begin
        rd_addr_q <= ADDR_W'(START_LAYER);
      end else if ((state_q == StNext) && !abort && !last_entry) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end

      if ((state_q == StLatch) && !abort) begin
        order_bus_q <= rd_data_q;
        layer_idx_q <= rd_addr_q;
      end
    end
  end

  assign calculate_start = calc_start_q;
  assign order_valid     = order_valid_q;
  assign task_done       = task_done_q;
  assign order_bus       = order_bus_q;
  assign layer_idx       = layer_idx_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: doc/order_sequencer.md
ORDER_SEQUENCER -- requirements
Module: order_sequencer

Interface
REQ-001 Parameter ORDER_WORDS, default 16: number of 32-bit fields per order entry.
REQ-002 Parameter ORDER_DEPTH, default 64: number of order entries; ADDR_W = clog2(ORDER_DEPTH).
REQ-003 Parameter START_LAYER, default 0: entry index fetched first after task_start.
REQ-004 system_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 task_start  in  1  single-cycle pulse; begins a run from START_LAYER.
REQ-007 abort  in  1  level; terminates the run.
REQ-008 calculate_finish  in  1  level from compute core; a rising edge ends the current order.
REQ-009 calculate_start  out  1  one-cycle pulse; tells the core the order on order_bus is valid to execute.
REQ-010 cfg_we  in  1  table write strobe.
REQ-011 cfg_addr  in  ADDR_W  entry index to write.
REQ-012 cfg_word_sel  in  clog2(ORDER_WORDS)  field index within the entry.
REQ-013 cfg_wdata  in  32  field write data.
REQ-014 order_bus  out  ORDER_WORDS*32  current order; field i at bits [32*i+:32]; field 0 bits [2:0] = opcode.
REQ-015 order_valid  out  1  order_bus holds a fetched, not yet retired order.
REQ-016 layer_idx  out  ADDR_W  index of the entry on order_bus.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 task_done  out  1  one-cycle pulse at normal end of run.

Function
REQ-019 Table: ORDER_DEPTH x ORDER_WORDS x 32 storage; synchronous read, 1-cycle latency; one 32-bit field written per cfg_we cycle.
REQ-020 cfg_we SHALL be honoured only in IDLE; writes while busy=1 are dropped and the table is unchanged.
REQ-021 FSM states: IDLE, FETCH, LATCH, ISSUE, WAIT, NEXT, DONE.
REQ-022 IDLE: on task_start=1 -> FETCH with read address = START_LAYER; otherwise remain.
REQ-023 FETCH: present read address -> LATCH.
REQ-024 LATCH: register entry into order_bus, layer_idx = read address; if opcode = 0 -> DONE (order_valid stays 0); else order_valid = 1 -> ISSUE.
REQ-025 ISSUE: calculate_start = 1 for exactly this one cycle -> WAIT.
REQ-026 Latency: calculate_start rises 3 edges after the edge that sampled task_start.
REQ-027 calculate_finish SHALL be registered every cycle (finish_r); edge = calculate_finish & ~finish_r.
REQ-028 WAIT: on edge -> NEXT; a finish already high when WAIT is entered SHALL NOT count (needs a fresh 0->1).
REQ-029 An edge occurring in any state other than WAIT SHALL be ignored.
REQ-030 NEXT: order_valid = 0; if read address = ORDER_DEPTH-1 -> DONE (no wrap); else address + 1 -> FETCH.
REQ-031 DONE: task_done = 1 for one cycle -> IDLE.
REQ-032 task_start while busy=1 SHALL be ignored.
REQ-033 abort=1 in any non-IDLE state -> IDLE on the next edge; calculate_start and order_valid drop to 0; no task_done. abort has priority over all other transitions.
REQ-034 Simultaneous task_start and abort in IDLE: abort wins, remain IDLE.
REQ-035 order_bus and layer_idx hold their last value in IDLE and change only in LATCH.

Reset
REQ-036 rst_n=0 at an edge: state = IDLE; calculate_start, order_valid, task_done, busy = 0; order_bus = 0; layer_idx = 0; finish_r = 0; read address = START_LAYER.
REQ-037 Reset mid-run behaves as REQ-036 with no task_done pulse; table contents are NOT cleared by reset.

Verification
REQ-038 Load entries 0,1,2 with opcode 1,2,3 and entry 3 opcode 0; pulse task_start -> calculate_start 3 edges later, layer_idx=0; three finish edges -> layer_idx 0,1,2 in turn, then task_done once, busy=0.
REQ-039 Hold calculate_finish=1 across ISSUE/WAIT -> no advance until it drops and rises again.
REQ-040 Fill all 64 entries with opcode 1 -> after 64th finish, task_done with layer_idx=63; no fetch of entry 0.
REQ-041 Assert abort in WAIT at layer 1 -> IDLE next edge, order_valid=0, no task_done; new task_start restarts at layer 0.
REQ-042 cfg_we during busy to entry 2 field 5 with 0xDEADBEEF -> entry unchanged when read on a later run.
REQ-043 rst_n=0 during WAIT -> all outputs at REQ-036 values next edge; table contents preserved for the next run.
